// File: rtl/pipe_mem.sv
// pipe_mem: MEM stage of a 5-stage pipeline. Holds the EX/MEM register,
// runs a two-state memory access FSM and forms lane-aligned load/store data.
// Latency: 2 edges from EX input to writeback output, plus one edge per cycle with ack low.
// Backpressure: out_stall = ACCESS & ~in_mem_ack; the stage holds its contents while stalled.
// Ports: in_clk/in_rst (sync, active-high); in_dmem_* / in_rd_* / in_flush from EX;
//        out_mem_* / in_mem_* memory request/ack; out_rd_*, out_wb_data, out_misalign writeback.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module pipe_mem (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_dmem_ena,
    input  logic        in_dmem_wena,
    input  logic [1:0]  in_dmem_type,
    input  logic        in_load_signed,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_rd_waddr,
    input  logic        in_rd_sel,
    input  logic        in_rd_wena,
    input  logic        in_flush,
    output logic        out_mem_req,
    output logic        out_mem_we,
    output logic [31:0] out_mem_addr,
    output logic [3:0]  out_mem_be,
    output logic [31:0] out_mem_wdata,
    input  logic        in_mem_ack,
    input  logic [31:0] in_mem_rdata,
    output logic        out_stall,
    output logic [4:0]  out_rd_waddr,
    output logic        out_rd_wena,
    output logic [31:0] out_wb_data,
    output logic        out_misalign
);

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state;
    logic        s_vld, s_ena, s_wena, s_signed, s_sel, s_rdwena;
    logic [1:0]  s_type;
    logic [31:0] s_rt, s_alu;
    logic [4:0]  s_rd;

    logic        in_mis, s_mis, access, mem_done;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Half needs addr[0]==0, word (type 00 or 11) needs addr[1:0]==0; bytes never trap.
    function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
        case (t)
            2'b01:   return a[0];
            2'b10:   return 1'b0;
            default: return a != 2'b00;
        endcase
    endfunction

    assign in_mis   = ALIGN_CHECK & misaligned(in_dmem_type, in_alu_result[1:0]);
    assign s_mis    = ALIGN_CHECK & misaligned(s_type, s_alu[1:0]);
    assign access   = (state == ACCESS);
    assign mem_done = access & in_mem_ack;
    assign out_stall = access & ~in_mem_ack;
    assign off      = s_alu[1:0];

    // Store lane steering; half uses only addr[1], word ignores the low bits.
    always_comb begin
        be    = 4'b1111;
        wdata = s_rt;
        case (s_type)
            2'b10: begin
                be    = 4'b0001 << off;
                wdata = {4{s_rt[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{s_rt[15:0]}};
            end
            default: ;
        endcase
    end

    // Request fields are driven only during ACCESS; the stage is frozen then, so they stay stable.
    assign out_mem_req   = access;
    assign out_mem_we    = access & s_wena;
    assign out_mem_addr  = access ? {s_alu[31:2], 2'b00} : 32'd0;
    assign out_mem_be    = access ? be : 4'd0;
    assign out_mem_wdata = access ? wdata : 32'd0;

    // Load lane extraction mirrors the store lane mapping.
    always_comb begin
        case (off)
            2'd0:    ld_byte = in_mem_rdata[7:0];
            2'd1:    ld_byte = in_mem_rdata[15:8];
            2'd2:    ld_byte = in_mem_rdata[23:16];
            default: ld_byte = in_mem_rdata[31:24];
        endcase
        ld_half = off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (s_type)
            2'b10:   ld_data = s_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            2'b01:   ld_data = s_signed ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: ld_data = in_mem_rdata;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state        <= IDLE;
            s_vld        <= 1'b0;
            s_ena        <= 1'b0;
            s_wena       <= 1'b0;
            s_type       <= 2'd0;
            s_signed     <= 1'b0;
            s_rt         <= 32'd0;
            s_alu        <= 32'd0;
            s_rd         <= 5'd0;
            s_sel        <= 1'b0;
            s_rdwena     <= 1'b0;
            out_rd_wena  <= 1'b0;
            out_rd_waddr <= 5'd0;
            out_wb_data  <= 32'd0;
            out_misalign <= 1'b0;
        end else begin
            // A memory op only writes back on its ack edge; a trapped op never gets there.
            out_rd_wena  <= s_vld & s_rdwena & (~s_ena | mem_done) & ~out_stall;
            out_rd_waddr <= s_rd;
            out_wb_data  <= s_sel ? ld_data : s_alu;
            out_misalign <= s_vld & s_ena & s_mis;
            if (!out_stall) begin
                s_vld    <= ~in_flush;
                s_ena    <= in_dmem_ena;
                s_wena   <= in_dmem_wena;
                s_type   <= in_dmem_type;
                s_signed <= in_load_signed;
                s_rt     <= in_rt_data;
                s_alu    <= in_alu_result;
                s_rd     <= in_rd_waddr;
                s_sel    <= in_rd_sel;
                s_rdwena <= in_rd_wena;
                state    <= (~in_flush & in_dmem_ena & ~in_mis) ? ACCESS : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: randomized scoreboard bench for pipe_mem with a byte-level memory model.
`timescale 1ns/1ps
module tb_pipe_mem;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_dmem_ena, in_dmem_wena, in_load_signed, in_rd_sel, in_rd_wena, in_flush;
    logic [1:0]  in_dmem_type;
    logic [31:0] in_rt_data, in_alu_result;
    logic [4:0]  in_rd_waddr;
    logic        out_mem_req, out_mem_we, in_mem_ack;
    logic [31:0] out_mem_addr, out_mem_wdata, in_mem_rdata;
    logic [3:0]  out_mem_be;
    logic        out_stall, out_rd_wena, out_misalign;
    logic [4:0]  out_rd_waddr;
    logic [31:0] out_wb_data;

    always #5 in_clk = ~in_clk;

    pipe_mem dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena), .in_dmem_type(in_dmem_type),
        .in_load_signed(in_load_signed), .in_rt_data(in_rt_data), .in_alu_result(in_alu_result),
        .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena), .in_flush(in_flush),
        .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
        .out_mem_be(out_mem_be), .out_mem_wdata(out_mem_wdata),
        .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata),
        .out_stall(out_stall), .out_rd_waddr(out_rd_waddr), .out_rd_wena(out_rd_wena),
        .out_wb_data(out_wb_data), .out_misalign(out_misalign)
    );

    typedef struct { bit kind; bit [4:0] rd; bit [31:0] data; int a; int snap; } ev_t;
    typedef struct { bit we; bit [31:0] addr; bit [3:0] be; bit [31:0] wdata; } req_t;

    ev_t  ev_q[$];
    req_t req_q[$];
    int compared = 0, mismatched = 0;
    int cyc = 0, stall_cnt = 0, req_cnt = 0, mis_cnt = 0, forced_wait = -1;
    bit last_stalled = 1'b0;
    bit [31:0] model_mem [bit [29:0]];
    bit [31:0] dut_mem [bit [29:0]];
    logic [31:0] last_wb, last_req_addr, last_req_wdata;
    logic [4:0]  last_rd;
    logic [3:0]  last_req_be;
    logic        last_req_we;
    int          last_lat;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit [31:0] init_word(bit [29:0] a);
        return {a, 2'b00} * 32'h9E37_79B1;
    endfunction

    always @(posedge in_clk) begin
        cyc <= cyc + 1;
        if (out_stall === 1'b1) stall_cnt <= stall_cnt + 1;
        last_stalled <= (out_stall === 1'b1);
    end

    task automatic bubble();
        in_dmem_ena = 0; in_dmem_wena = 0; in_dmem_type = 0; in_load_signed = 0;
        in_rd_sel = 0; in_rd_wena = 0; in_flush = 0; in_rd_waddr = 0;
        in_rt_data = $urandom; in_alu_result = $urandom;
    endtask

    // Drives one op until it is captured, then records its expected effects.
    task automatic issue(bit ena, bit we, bit [1:0] ty, bit sgn, bit [31:0] rt,
                         bit [31:0] alu, bit [4:0] rd, bit sel, bit rdw, bit fl);
        int sz, off, a, snap;
        bit accepted = 0;
        bit mis;
        bit [31:0] word, ld, mask, wd;
        bit [3:0] be;
        in_dmem_ena = ena; in_dmem_wena = we; in_dmem_type = ty; in_load_signed = sgn;
        in_rt_data = rt; in_alu_result = alu; in_rd_waddr = rd; in_rd_sel = sel;
        in_rd_wena = rdw; in_flush = fl;
        for (int i = 0; i < 100; i++) begin
            @(posedge in_clk); #1;
            if (!last_stalled) begin accepted = 1; break; end
        end
        bubble();
        if (!accepted) begin
            compared++; mismatched++;
            $display("FAIL issue_accept: op not captured within 100 cycles");
            return;
        end
        a = cyc; snap = stall_cnt;
        if (fl) return;
        sz   = (ty == 2'b10) ? 1 : (ty == 2'b01) ? 2 : 4;
        off  = int'(alu[1:0]);
        mis  = ALIGN_EN && ena && (off % sz != 0);
        off  = off - off % sz;
        ld   = alu;
        if (mis) begin
            ev_q.push_back('{1'b1, rd, 32'd0, a, snap});
            return;
        end
        if (ena) begin
            word = model_mem.exists(alu[31:2]) ? model_mem[alu[31:2]] : init_word(alu[31:2]);
            be   = 4'((1 << sz) - 1) << off;
            wd   = (sz == 1) ? rt[7:0] * 32'h0101_0101 : (sz == 2) ? rt[15:0] * 32'h0001_0001 : rt;
            req_q.push_back('{we, {alu[31:2], 2'b00}, be, wd});
            if (we) begin
                for (int i = 0; i < sz; i++) word[8*(off+i) +: 8] = rt[8*i +: 8];
                model_mem[alu[31:2]] = word;
            end else if (sel) begin
                mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
                ld = (word >> (8 * off)) & mask;
                if (sgn && sz < 4 && ld[8*sz-1]) ld = ld | ~mask;
            end
        end
        if (rdw) ev_q.push_back('{1'b0, rd, ld, a, snap});
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge in_clk); #1;
            if (ev_q.size() == 0 && !out_mem_req) begin done = 1; break; end
        end
        @(posedge in_clk); #1;
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: %0d events still pending", ev_q.size());
        end
    endtask

    // Memory responder: checks each request against the expected queue, then acks after a wait.
    initial begin
        bit busy = 0;
        int wait_left = 0;
        req_t first, e;
        in_mem_ack = 0; in_mem_rdata = 0;
        forever begin
            @(negedge in_clk);
            if (in_rst || !out_mem_req) begin
                busy = 0;
                in_mem_ack = !in_rst && ($urandom_range(0, 3) == 0);
                in_mem_rdata = $urandom;
            end else begin
                if (!busy) begin
                    busy = 1;
                    first = '{out_mem_we, out_mem_addr, out_mem_be, out_mem_wdata};
                    req_cnt++;
                    last_req_we = out_mem_we; last_req_addr = out_mem_addr;
                    last_req_be = out_mem_be; last_req_wdata = out_mem_wdata;
                    wait_left = (forced_wait >= 0) ? forced_wait : $urandom_range(0, 3);
                    if (req_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_req: addr %0h", out_mem_addr);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_we", out_mem_we, e.we);
                        chk("req_addr", out_mem_addr, e.addr);
                        chk("req_be", out_mem_be, e.be);
                        if (e.we) chk("req_wdata", out_mem_wdata, e.wdata);
                    end
                end else begin
                    chk("req_stable", {out_mem_we, out_mem_addr, out_mem_be, out_mem_wdata},
                        {first.we, first.addr, first.be, first.wdata});
                end
                if (wait_left == 0) begin
                    in_mem_ack = 1;
                    in_mem_rdata = dut_mem.exists(out_mem_addr[31:2]) ? dut_mem[out_mem_addr[31:2]]
                                                                      : init_word(out_mem_addr[31:2]);
                    if (out_mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (out_mem_be[i]) in_mem_rdata[8*i +: 8] = out_mem_wdata[8*i +: 8];
                        dut_mem[out_mem_addr[31:2]] = in_mem_rdata;
                        in_mem_rdata = $urandom;
                    end
                    busy = 0;
                end else begin
                    in_mem_ack = 0;
                    in_mem_rdata = $urandom;
                    wait_left--;
                end
            end
        end
    end

    // Writeback monitor.
    initial begin
        ev_t e;
        forever begin
            @(negedge in_clk);
            if (last_stalled && !in_rst) chk("bubble_on_stall", out_rd_wena, 1'b0);
            if (out_misalign === 1'b1) mis_cnt++;
            if (out_rd_wena === 1'b1 || out_misalign === 1'b1) begin
                if (ev_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_wb: rd %0d data %0h misalign %0b",
                             out_rd_waddr, out_wb_data, out_misalign);
                end else begin
                    e = ev_q.pop_front();
                    chk("wb_kind", out_misalign, e.kind);
                    if (e.kind) chk("mis_wena", out_rd_wena, 1'b0);
                    else begin
                        chk("wb_rd", out_rd_waddr, e.rd);
                        chk("wb_data", out_wb_data, e.data);
                    end
                    chk("wb_latency", cyc - e.a - 1, stall_cnt - e.snap);
                    last_wb = out_wb_data; last_rd = out_rd_waddr; last_lat = cyc - e.a + 1;
                end
            end
        end
    end

    initial begin
        int n, m, s0;
        bit ena, we;
        bubble();
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        chk("rst_stall", out_stall, 1'b0);
        chk("rst_req", out_mem_req, 1'b0);
        chk("rst_wena", out_rd_wena, 1'b0);
        chk("rst_wb", {out_rd_waddr, out_wb_data, out_misalign}, 38'd0);
        @(posedge in_clk); #1;
        in_rst = 0;

        // ALU op
        s0 = stall_cnt;
        issue(0, 0, 0, 0, $urandom, 32'h0000_1234, 5'd5, 0, 1, 0);
        drain();
        chk("alu_rd", last_rd, 5'd5);
        chk("alu_data", last_wb, 32'h0000_1234);
        chk("alu_latency", last_lat, 2);
        chk("alu_nostall", stall_cnt - s0, 0);

        // Byte store with three wait cycles
        forced_wait = 3; s0 = stall_cnt;
        issue(1, 1, 2'b10, 0, 32'hAABB_CCDD, 32'h0000_0103, 5'd0, 0, 0, 0);
        drain();
        chk("bst_addr", last_req_addr, 32'h100);
        chk("bst_be", last_req_be, 4'b1000);
        chk("bst_wdata", last_req_wdata, 32'hDDDD_DDDD);
        chk("bst_we", last_req_we, 1'b1);
        chk("bst_stalls", stall_cnt - s0, 3);

        // Half loads from 0x202 after storing 0x8001_0000 at 0x200
        forced_wait = 0;
        issue(1, 1, 2'b00, 0, 32'h8001_0000, 32'h200, 5'd0, 0, 0, 0);
        issue(1, 0, 2'b01, 1, $urandom, 32'h202, 5'd7, 1, 1, 0);
        drain();
        chk("lh_signed", last_wb, 32'hFFFF_8001);
        issue(1, 0, 2'b01, 0, $urandom, 32'h202, 5'd7, 1, 1, 0);
        drain();
        chk("lh_unsigned", last_wb, 32'h0000_8001);
        forced_wait = -1;

        // Flushed load followed by an ALU op
        n = req_cnt;
        issue(1, 0, 2'b00, 0, $urandom, 32'h300, 5'd8, 1, 1, 1);
        issue(0, 0, 2'b00, 0, $urandom, 32'h55, 5'd9, 0, 1, 0);
        drain();
        chk("flush_noreq", req_cnt - n, 0);
        chk("flush_next_rd", last_rd, 5'd9);
        chk("flush_next_data", last_wb, 32'h55);

        // Reset during a long access
        forced_wait = 20;
        issue(1, 0, 2'b00, 0, $urandom, 32'h340, 5'd3, 1, 1, 0);
        repeat (3) @(posedge in_clk);
        #1 in_rst = 1;
        @(posedge in_clk);
        @(negedge in_clk);
        chk("mid_rst_req", out_mem_req, 1'b0);
        chk("mid_rst_stall", out_stall, 1'b0);
        chk("mid_rst_outs", {out_rd_wena, out_rd_waddr, out_wb_data, out_misalign}, 39'd0);
        if (ev_q.size() > 0) void'(ev_q.pop_back());
        in_rst = 0;
        forced_wait = -1;
        @(posedge in_clk); #1;

        // Word load at 0x2
        n = req_cnt; m = mis_cnt;
        issue(1, 0, 2'b00, 0, $urandom, 32'h2, 5'd4, 1, 1, 0);
        drain();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_noreq", req_cnt - n, 0);
        chk("mis_pulse", mis_cnt - m, 1);
`else
        chk("mis_req_addr", last_req_addr, 32'h0);
        chk("mis_req_be", last_req_be, 4'hF);
        chk("mis_wb_rd", last_rd, 5'd4);
`endif

        // Randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            ena = ($urandom_range(0, 1) == 1);
            we  = ena && ($urandom_range(0, 1) == 1);
            if (ena)
                issue(1, we, 2'($urandom), 1'($urandom), $urandom,
                      32'h400 + $urandom_range(0, 63), 5'($urandom), !we,
                      we ? ($urandom_range(0, 3) == 0) : 1'b1, $urandom_range(0, 7) == 0);
            else
                issue(0, 0, 2'($urandom), 0, $urandom, $urandom, 5'($urandom), 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin @(posedge in_clk); #1; end
        end
        drain();
        chk("end_ev_empty", ev_q.size(), 0);
        chk("end_req_empty", req_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
